// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolver with bimodal BHT.
// Resolves BRANCH/JAL/JALR, flags mispredicts against the fetch prediction,
// and trains a table of 2-bit counters that fetch reads via lookup_pc.
// Optional: BRANCH_MISALIGN_EN adds res_misalign and hands misaligned
// taken targets to the trap path instead of redirecting.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_op_a,
    input  logic [XLEN-1:0] in_op_b,
    input  logic            in_pred_taken,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic [XLEN-1:0] res_next_pc,
    output logic            res_mispredict,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
`ifdef BRANCH_MISALIGN_EN
    ,
    output logic            res_misalign
`endif
);

    localparam int         BHT_N     = 1 << BHT_IDX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic                 accept;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      imm_b, imm_j, imm_i;
    logic [XLEN-1:0]      pc_plus4;
    logic                 is_branch;
    logic                 cond;
    logic                 taken_d;
    logic [XLEN-1:0]      target_d;
    logic                 misalign_d;
    logic [XLEN-1:0]      next_pc_d;
    logic                 mispredict_d;
    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx, lk_idx;
    logic                 unused_lookup_bits;

    // A new input may enter whenever the result slot is empty or draining.
    assign in_ready = !res_valid || res_ready;
    assign accept   = in_valid && in_ready && !flush;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign imm_b    = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j    = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    assign imm_i    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign pc_plus4 = in_pc + XLEN'(4);

    // Branch condition; reserved funct3 codes resolve not-taken.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (in_op_a == in_op_b);
            3'b001:  cond = (in_op_a != in_op_b);
            3'b100:  cond = ($signed(in_op_a) <  $signed(in_op_b));
            3'b101:  cond = ($signed(in_op_a) >= $signed(in_op_b));
            3'b110:  cond = (in_op_a <  in_op_b);
            3'b111:  cond = (in_op_a >= in_op_b);
            default: cond = 1'b0;
        endcase
    end

    // Opcode decode: direction and target for every instruction class.
    always_comb begin
        is_branch = 1'b0;
        taken_d   = 1'b0;
        target_d  = pc_plus4;
        case (opcode)
            OP_BRANCH: begin
                is_branch = 1'b1;
                taken_d   = cond;
                target_d  = in_pc + imm_b;
            end
            OP_JAL: begin
                taken_d  = 1'b1;
                target_d = in_pc + imm_j;
            end
            OP_JALR: begin
                taken_d  = 1'b1;
                target_d = (in_op_a + imm_i) & ~XLEN'(1);
            end
            default: ;
        endcase
    end

`ifdef BRANCH_MISALIGN_EN
    assign misalign_d = taken_d && (target_d[1:0] != 2'b00);
`else
    assign misalign_d = 1'b0;
`endif

    // A misaligned taken target falls through; the trap handler redirects.
    assign next_pc_d    = (taken_d && !misalign_d) ? target_d : pc_plus4;
    assign mispredict_d = misalign_d ? 1'b0 : (taken_d ^ in_pred_taken);

    // Result register: flush wins, then accept, then drain on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
        end else if (flush) begin
            res_valid <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    // Result payload only loads on accept, so it is stable while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_taken      <= 1'b0;
            res_target     <= '0;
            res_next_pc    <= '0;
            res_mispredict <= 1'b0;
        end else if (accept) begin
            res_taken      <= taken_d;
            res_target     <= target_d;
            res_next_pc    <= next_pc_d;
            res_mispredict <= mispredict_d;
        end
    end

`ifdef BRANCH_MISALIGN_EN
    // Misalign flag travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_misalign <= 1'b0;
        end else if (accept) begin
            res_misalign <= misalign_d;
        end
    end
`endif

    assign upd_idx = in_pc[BHT_IDX_W+1:2];
    assign lk_idx  = lookup_pc[BHT_IDX_W+1:2];

    // BHT training: saturating 2-bit counters, conditional branches only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (accept && is_branch) begin
            if (taken_d && bht[upd_idx] != 2'b11)
                bht[upd_idx] <= bht[upd_idx] + 2'b01;
            else if (!taken_d && bht[upd_idx] != 2'b00)
                bht[upd_idx] <= bht[upd_idx] - 2'b01;
        end
    end

    // Lookup sees the pre-update value when it hits the entry being written.
    assign lookup_taken = bht[lk_idx][1];

    // Only the index bits of lookup_pc address the table.
    assign unused_lookup_bits = ^{lookup_pc[XLEN-1:BHT_IDX_W+2], lookup_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (XLEN=32, BHT_IDX_W=6).
// Directed test-plan scenarios followed by randomized traffic, all compared
// against a transaction-level model of the result slot and the BHT.
module tb_branch_resolve_unit;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_pred_taken, flush;
    logic [31:0] in_instr, in_pc, in_op_a, in_op_b;
    logic        res_valid, res_ready, res_taken, res_mispredict;
    logic [31:0] res_target, res_next_pc, lookup_pc;
    logic        lookup_taken;
`ifdef BRANCH_MISALIGN_EN
    logic        res_misalign;
`endif

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_pred_taken(in_pred_taken), .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .res_next_pc(res_next_pc),
        .res_mispredict(res_mispredict),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
`ifdef BRANCH_MISALIGN_EN
        , .res_misalign(res_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit          m_valid;
    bit          m_taken, m_misp, m_mis;
    logic [31:0] m_target, m_npc;
    int          bht [64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_misp = 0; m_mis = 0;
        m_target = 0; m_npc = 0;
        for (int i = 0; i < 64; i++) bht[i] = 1;
    endtask

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] v;
        v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input int imm);
        logic [11:0] v;
        v = 12'(imm);
        return {v, 5'd1, 3'b000, 5'd1, 7'b1100111};
    endfunction

    // kind: 0 branch, 1 jal, 2 jalr, 3 non-control
    task automatic cycle(input bit v, input int kind, input logic [2:0] f3, input int imm,
                         input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input bit pt, input bit fl, input bit rr, input logic [31:0] lpc);
        logic [31:0] r, tgt, np;
        bit          acc, tk, ms;
        longint      sa, sb;
        int          li;
        r = $urandom;
        case (kind)
            0:       in_instr = enc_b(imm, f3);
            1:       in_instr = enc_j(imm);
            2:       in_instr = enc_i(imm);
            default: in_instr = {r[31:7], 7'b0110011};
        endcase
        in_valid = v; in_pc = pc; in_op_a = a; in_op_b = b;
        in_pred_taken = pt; flush = fl; res_ready = rr; lookup_pc = lpc;
        #4;
        li = int'(lpc[7:2]);
        check("in_ready", in_ready, !m_valid || rr);
        check("lookup_taken", lookup_taken, bht[li] >= 2);

        acc = v && (!m_valid || rr) && !fl;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        tk = 0;
        tgt = pc + 32'd4;
        case (kind)
            0: begin
                tgt = pc + 32'(imm);
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (sa < sb);
                    3'd5: tk = (sa >= sb);
                    3'd6: tk = (a < b);
                    3'd7: tk = (a >= b);
                    default: tk = 0;
                endcase
            end
            1: begin tk = 1; tgt = pc + 32'(imm); end
            2: begin tk = 1; tgt = (a + 32'(imm)) & 32'hFFFF_FFFE; end
            default: ;
        endcase
`ifdef BRANCH_MISALIGN_EN
        ms = tk && (tgt % 4 != 0);
`else
        ms = 0;
`endif
        np = (tk && !ms) ? tgt : pc + 32'd4;

        @(posedge clk);
        #1;
        if (acc && kind == 0) begin
            li = int'(pc[7:2]);
            if (tk) bht[li] = (bht[li] == 3) ? 3 : bht[li] + 1;
            else    bht[li] = (bht[li] == 0) ? 0 : bht[li] - 1;
        end
        if (acc) begin
            m_taken = tk; m_target = tgt; m_npc = np;
            m_misp = ms ? 1'b0 : (tk ^ pt); m_mis = ms;
        end
        if (fl)        m_valid = 0;
        else if (acc)  m_valid = 1;
        else if (rr)   m_valid = 0;

        check("res_valid", res_valid, m_valid);
        if (m_valid) begin
            check("res_taken", res_taken, m_taken);
            check("res_target", res_target, m_target);
            check("res_next_pc", res_next_pc, m_npc);
            check("res_mispredict", res_mispredict, m_misp);
`ifdef BRANCH_MISALIGN_EN
            check("res_misalign", res_misalign, m_mis);
`endif
        end
    endtask

    function automatic int rnd_imm(input int kind);
        int r;
        case (kind)
            0: begin r = int'($urandom_range(0, 8191)) & ~1;  return (r >= 4096) ? r - 8192 : r; end
            1: begin r = int'($urandom & 32'h1F_FFFE);        return (r >= (1 << 20)) ? r - (1 << 21) : r; end
            default: begin r = int'($urandom_range(0, 4095)); return (r >= 2048) ? r - 4096 : r; end
        endcase
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return other;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] pc, a, b, lp;
        int          k;
        rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; in_op_a = 0; in_op_b = 0;
        in_pred_taken = 0; flush = 0; res_ready = 0; lookup_pc = 0;
        model_reset();
        #12;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_taken", res_taken, 0);
        check("rst_res_target", res_target, 0);
        check("rst_res_next_pc", res_next_pc, 0);
        check("rst_res_mispredict", res_mispredict, 0);
        check("rst_lookup", lookup_taken, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // signed vs unsigned compare
        cycle(1, 0, 3'd4, 16, 32'h80, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 32'h80);
        check("blt_taken", res_taken, 1);
        check("blt_mispredict", res_mispredict, 1);
        check("blt_next_pc", res_next_pc, 32'h90);
        cycle(1, 0, 3'd6, 16, 32'h80, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 32'h80);
        check("bltu_taken", res_taken, 0);
        check("bltu_mispredict", res_mispredict, 0);

        // JALR leaves the BHT alone
        cycle(1, 2, 3'd0, 4, 32'h200, 32'h1003, 32'h0, 0, 0, 1, 32'h200);
        check("jalr_target", res_target, 32'h1006);
        check("jalr_taken", res_taken, 1);
`ifndef BRANCH_MISALIGN_EN
        check("jalr_next_pc", res_next_pc, 32'h1006);
`endif
        cycle(0, 3, 3'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h200);

        // BHT saturation at pc 0x40
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 3'd0, 8, 32'h40, 32'h5, 32'h5, 0, 0, 1, 32'h40);
            check("sat_up_lookup", lookup_taken, 1);
        end
        for (int i = 0; i < 2; i++)
            cycle(1, 0, 3'd0, 8, 32'h40, 32'h5, 32'h6, 0, 0, 1, 32'h40);
        check("sat_down_lookup", lookup_taken, 0);

        // backpressure then release
        cycle(1, 0, 3'd1, -8, 32'h44, 32'h1, 32'h2, 1, 0, 1, 32'h44);
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 3'd1, -8, 32'h44, 32'h1, 32'h2, 0, 0, 0, 32'h44);
        cycle(1, 1, 3'd0, 64, 32'h300, 32'h0, 32'h0, 0, 0, 1, 32'h44);
        check("release_target", res_target, 32'h340);

        // flush with a held result and a same-cycle input
        cycle(1, 0, 3'd0, 8, 32'h40, 32'h7, 32'h7, 0, 0, 0, 32'h40);
        check("hold_before_flush", res_valid, 1);
        cycle(1, 0, 3'd0, 8, 32'h40, 32'h7, 32'h7, 0, 1, 0, 32'h40);
        check("flush_valid", res_valid, 0);
        cycle(0, 3, 3'd0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 32'h40);

`ifdef BRANCH_MISALIGN_EN
        cycle(1, 1, 3'd0, 2, 32'h100, 32'h0, 32'h0, 1, 0, 1, 32'h100);
        check("mis_flag", res_misalign, 1);
        check("mis_next_pc", res_next_pc, 32'h104);
        check("mis_mispredict", res_mispredict, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            k  = int'($urandom_range(0, 3));
            pc = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            a  = rnd_op(32'h0);
            b  = rnd_op(a);
            lp = ($urandom_range(0, 1) == 0) ? pc : $urandom;
            cycle($urandom_range(0, 9) < 8, k, 3'($urandom_range(0, 7)), rnd_imm(k),
                  pc, a, b, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7, lp);
        end

        // asynchronous reset while a result is held
        cycle(1, 0, 3'd0, 8, 32'h40, 32'h3, 32'h3, 0, 0, 1, 32'h40);
        cycle(1, 0, 3'd0, 8, 32'h40, 32'h3, 32'h3, 0, 0, 0, 32'h40);
        check("pre_reset_valid", res_valid, 1);
        rst_n = 0;
        #1;
        check("async_rst_valid", res_valid, 0);
        model_reset();
        in_valid = 0; flush = 0; res_ready = 1;
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i) << 2;
            #1;
            check("rst_bht_entry", lookup_taken, bht[i] >= 2);
        end
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 3'd0, 8, 32'h40, 32'h9, 32'h9, 0, 0, 1, 32'h40);
        check("post_reset_lookup", lookup_taken, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator in the rv32i core.
- Resolves conditional branches, JAL and JALR, and computes taken/target/next-PC. Detects mispredicts against the fetch-stage prediction.
- Maintains a bimodal branch history table (BHT) of 2-bit counters, which fetch reads through a lookup port.
- Sits between execute and the fetch redirect logic, using a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath and PC width; legal values 32 or 64.
- BHT_IDX_W, 6, BHT index width; the table has 2**BHT_IDX_W entries.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept; equals !res_valid || res_ready (combinational).
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- in_op_a  in  XLEN  rs1 value.
- in_op_b  in  XLEN  rs2 value.
- in_pred_taken  in  1  prediction made by fetch.
- flush  in  1  kill the held result and any same-cycle input.
- res_valid  out  1  result register valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  resolved direction.
- res_target  out  XLEN  computed target, whether or not taken.
- res_next_pc  out  XLEN  taken ? target : pc+4.
- res_mispredict  out  1  res_taken != predicted direction.
- lookup_pc  in  XLEN  fetch PC for BHT read.
- lookup_taken  out  1  MSB of the indexed counter (combinational read).
- res_misalign  out  1  present only with BRANCH_MISALIGN_EN.

Behaviour:
- Reset: res_valid=0; res_taken, res_mispredict and res_misalign are 0; res_target and res_next_pc are 0. All BHT counters reset to 2'b01 (weakly not-taken).
- Accept: an input is accepted when in_valid && in_ready && !flush. The result is registered with 1-cycle latency (res_valid=1 on the next edge).
- Hold: while res_valid && !res_ready, all res_* outputs are held stable and in_ready=0.
- Flush: on the next edge res_valid=0. Same-cycle input is dropped and its BHT update is suppressed. Flush overrides res_ready.
- Decode on opcode in_instr[6:0]:
  - BRANCH 1100011: target = pc + sext(B-imm).
  - JAL 1101111: taken=1; target = pc + sext(J-imm).
  - JALR 1100111: taken=1; target = (op_a + sext(I-imm)) & ~1.
  - Any other opcode: taken=0, target=pc+4.
- Branch conditions on funct3:
  - 000 beq: a==b.
  - 001 bne: a!=b.
  - 100 blt: signed a<b.
  - 101 bge: signed a>=b.
  - 110 bltu: unsigned a<b.
  - 111 bgeu: unsigned a>=b.
  - 010 and 011: not taken; the BHT is still updated as not-taken.
- Signed compares must be genuinely two's-complement at width XLEN. All adds are modulo 2**XLEN, so wrap-around is silent.
- Mispredict: res_mispredict = res_taken ^ in_pred_taken, as captured at accept. Non-control opcodes with pred_taken=1 flag a mispredict.
- BHT index: pc[BHT_IDX_W+1:2] for both update and lookup.
- BHT update: on accept of a BRANCH opcode only, the counter saturating-increments if taken and saturating-decrements if not. 11 stays 11 and 00 stays 00.
- BHT write takes effect on the accept edge. A same-cycle lookup of that index returns the pre-update value.
- JAL and JALR never touch the BHT.
- Reset asserted mid-operation: outputs and BHT return to reset values immediately. An in-flight result is lost.

Optional Feature:
- Macro: BRANCH_MISALIGN_EN.
- Defined: res_misalign port exists. It is registered with the result and is 1 when the instruction is taken and target[1:0]!=0. When it is 1, res_next_pc = pc+4 and res_mispredict is forced to 0, so the trap handler owns the redirect.
- Undefined: the port is absent and misaligned targets are redirected normally.

Test Plan:
- Signed compare: blt, a=0xFFFFFFFF, b=1, pred=0 -> taken=1, mispredict=1, next_pc=pc+imm. Same operands with bltu -> taken=0, mispredict=0.
- JALR: a=0x1003, imm=4, pc=0x200 -> target=0x1006, next_pc=0x1006, taken=1. The BHT entry for pc 0x200 stays 01.
- BHT saturation: beq at pc 0x40 taken 3 times -> lookup_taken for 0x40 reads 1,1,1 after each accept (counter 10,11,11). Then not taken twice -> counter 01 and lookup_taken=0.
- Backpressure: hold res_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no BHT change. Release -> next input accepted on the same cycle as the result handshake.
- Flush: flush=1 with in_valid=1 and res_valid=1 -> next cycle res_valid=0 and the BHT is unchanged. Also assert rst_n=0 mid-hold -> res_valid drops immediately and all BHT entries read 0.
- BRANCH_MISALIGN_EN: jal with imm=2 from pc 0x100 -> res_misalign=1, next_pc=0x104, mispredict=0.
